// File: rtl/toeplitz_pkg.sv
// rtl/toeplitz_pkg.sv - shared frame geometry and scheduler state encoding for the Toeplitz result path
package toeplitz_pkg;

    localparam int RESULT_W   = 3072;
    localparam int WORD_W     = 32;
    localparam int WORDS      = RESULT_W / WORD_W;
    localparam int FIFO_DEPTH = 1024;
    localparam int FRAME_CYC  = 2 * WORDS + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin arbiter; the last-grant pointer lives in the caller
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_src,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |req;
    // On a tie the producer that did not win last time goes next.
    assign grant_idx   = (req == 2'b11) ? ~last_src : req[1];

endmodule

// File: rtl/result_fifo_scheduler.sv
// rtl/result_fifo_scheduler.sv - schedules two hash producers onto the result serializer and gates FIFO reads
module result_fifo_scheduler #(
    parameter int RESULT_W   = 3072,
    parameter int WORDS      = 96,
    parameter int FIFO_DEPTH = 1024,
    parameter int FRAME_CYC  = 194
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [RESULT_W-1:0] res0,
    input  logic [RESULT_W-1:0] res1,
    output logic [1:0]          ack,
    output logic [RESULT_W-1:0] final_result,
    output logic                ser_write_en,
    input  logic                host_rd_en,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    output logic [10:0]         occupancy,
    output logic                busy,
    output logic                last_src
);

    import toeplitz_pkg::*;

    localparam logic [10:0] ADMIT_MAX  = 11'(FIFO_DEPTH - WORDS);
    localparam logic [10:0] FRAME_WRDS = 11'(WORDS);
    localparam logic [7:0]  DRAIN_LAST = 8'(FRAME_CYC - 3);

    sched_state_e state_q;
    logic         sel_q;
    logic         last_src_q;
    logic [10:0]  occ_q;
    logic [10:0]  occ_d;
    logic [7:0]   cnt_q;
    logic         ser_write_en_q;
    logic [1:0]   ack_q;

    logic grant_valid;
    logic grant_idx;
    logic admit;

    rr_arb2 u_arb (
        .req         (req),
        .last_src    (last_src_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign fifo_rd_en = host_rd_en & ~fifo_empty;
    // A frame is admitted only when all of its words are guaranteed a FIFO slot.
    assign admit      = grant_valid && (occ_q <= ADMIT_MAX);

    always_comb begin
        occ_d = occ_q;
        if (state_q == START) begin
            occ_d = occ_d + FRAME_WRDS;
        end
        if (fifo_rd_en) begin
            occ_d = occ_d - 11'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sel_q          <= 1'b0;
            last_src_q     <= 1'b1;
            occ_q          <= 11'd0;
            cnt_q          <= 8'd0;
            ser_write_en_q <= 1'b0;
            ack_q          <= 2'b00;
        end else begin
            ser_write_en_q <= 1'b0;
            ack_q          <= 2'b00;
            occ_q          <= occ_d;
            case (state_q)
                IDLE: begin
                    if (admit) begin
                        sel_q          <= grant_idx;
                        last_src_q     <= grant_idx;
                        ser_write_en_q <= 1'b1;
                        state_q        <= START;
                    end
                end
                START: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    // Serializer has sampled final_result at this edge; release the producer.
                    ack_q   <= sel_q ? 2'b10 : 2'b01;
                    cnt_q   <= 8'd0;
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign final_result = sel_q ? res1 : res0;
    assign ser_write_en = ser_write_en_q;
    assign ack          = ack_q;
    assign occupancy    = occ_q;
    assign busy         = (state_q != IDLE);
    assign last_src     = last_src_q;

endmodule

// File: tb/tb_result_fifo_scheduler.sv
// tb/tb_result_fifo_scheduler.sv - self-checking bench for result_fifo_scheduler
module tb_result_fifo_scheduler;

    import toeplitz_pkg::*;

    logic                clk_in = 1'b0;
    logic                rst;
    logic [1:0]          req;
    logic [RESULT_W-1:0] res0;
    logic [RESULT_W-1:0] res1;
    logic [1:0]          ack;
    logic [RESULT_W-1:0] final_result;
    logic                ser_write_en;
    logic                host_rd_en;
    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [10:0]         occupancy;
    logic                busy;
    logic                last_src;

    result_fifo_scheduler #(
        .RESULT_W   (RESULT_W),
        .WORDS      (WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FRAME_CYC  (FRAME_CYC)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .req          (req),
        .res0         (res0),
        .res1         (res1),
        .ack          (ack),
        .final_result (final_result),
        .ser_write_en (ser_write_en),
        .host_rd_en   (host_rd_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .occupancy    (occupancy),
        .busy         (busy),
        .last_src     (last_src)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int swe_count = 0;
    int          exp_src_q[$];
    logic [31:0] exp_word_q[$];

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (ser_write_en === 1'b1) swe_count <= swe_count + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        host_rd_en = 1'b0;
        fifo_empty = 1'b1;
        exp_src_q.delete();
        exp_word_q.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic push_frame(input int src);
        exp_src_q.push_back(src);
        for (int w = 0; w < WORDS; w++)
            exp_word_q.push_back(src != 0 ? res1[w*32 +: 32] : res0[w*32 +: 32]);
    endtask

    task automatic wait_swe(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (ser_write_en === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        host_rd_en = 1'b0;
        fifo_empty = 1'b1;
        tick(2);
        n_cmp++;
        if ({ser_write_en, ack, busy, last_src, occupancy} !== {1'b0, 2'b00, 1'b0, 1'b1, 11'd0}) begin
            n_err++;
            $display("FAIL reset_values got swe=%b ack=%b busy=%b last=%b occ=%0d want 0 00 0 1 0",
                     ser_write_en, ack, busy, last_src, occupancy);
        end
        rst = 1'b0;
        tick(3);
        n_cmp++;
        if (busy !== 1'b0 || ser_write_en !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req got busy=%b swe=%b want 0 0", busy, ser_write_en);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        int g1;
        int s0;
        logic [31:0] exp;
        do_reset();
        s0 = swe_count;
        req = 2'b01;
        push_frame(0);
        wait_swe(10, ok, g1);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_start got none want ser_write_en within 10 cycles");
            return;
        end
        void'(exp_src_q.pop_front());
        n_cmp++;
        if (busy !== 1'b1 || ack !== 2'b00) begin
            n_err++;
            $display("FAIL single_start_state got busy=%b ack=%b want 1 00", busy, ack);
        end
        tick(1);
        n_cmp++;
        if (occupancy !== 11'd96) begin
            n_err++;
            $display("FAIL single_occ got %0d want 96", occupancy);
        end
        for (int w = 0; w < WORDS; w++) begin
            exp = exp_word_q.pop_front();
            n_cmp++;
            if (final_result[w*32 +: 32] !== exp) begin
                n_err++;
                $display("FAIL single_word%0d got %h want %h", w, final_result[w*32 +: 32], exp);
            end
        end
        tick(1);
        n_cmp++;
        if (ack !== 2'b01) begin
            n_err++;
            $display("FAIL single_ack got %b want 01", ack);
        end
        req = 2'b00;
        tick(1);
        n_cmp++;
        if (ack !== 2'b00) begin
            n_err++;
            $display("FAIL single_ack_pulse got %b want 00", ack);
        end
        wait_idle(300, ok);
        n_cmp++;
        if (!ok || (cyc - g1) != FRAME_CYC) begin
            n_err++;
            $display("FAIL single_idle_return got ok=%0d dt=%0d want 1 %0d", ok, cyc - g1, FRAME_CYC);
        end
        n_cmp++;
        if (swe_count - s0 != 1) begin
            n_err++;
            $display("FAIL single_start_count got %0d want 1", swe_count - s0);
        end
        n_cmp++;
        if (occupancy !== 11'd96) begin
            n_err++;
            $display("FAIL single_occ_hold got %0d want 96", occupancy);
        end
    endtask

    task automatic test_read_gating();
        fifo_empty = 1'b1;
        host_rd_en = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL gate_empty got %b want 0", fifo_rd_en);
        end
        tick(3);
        n_cmp++;
        if (occupancy !== 11'd96) begin
            n_err++;
            $display("FAIL gate_empty_occ got %0d want 96", occupancy);
        end
        fifo_empty = 1'b0;
        #1;
        n_cmp++;
        if (fifo_rd_en !== 1'b1) begin
            n_err++;
            $display("FAIL gate_read got %b want 1", fifo_rd_en);
        end
        tick(96);
        host_rd_en = 1'b0;
        n_cmp++;
        if (occupancy !== 11'd0) begin
            n_err++;
            $display("FAIL drain_occ got %0d want 0", occupancy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int at;
        int prev;
        int src;
        logic [31:0] exp;
        do_reset();
        req = 2'b11;
        push_frame(0); push_frame(1); push_frame(0); push_frame(1);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_swe(k == 0 ? 10 : 250, ok, at);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL rr_start%0d got none want ser_write_en", k);
                req = 2'b00;
                return;
            end
            src = exp_src_q.pop_front();
            if (k > 0) begin
                n_cmp++;
                if (at - prev != FRAME_CYC + 1) begin
                    n_err++;
                    $display("FAIL rr_spacing%0d got %0d want %0d", k, at - prev, FRAME_CYC + 1);
                end
            end
            prev = at;
            n_cmp++;
            if (last_src !== src[0]) begin
                n_err++;
                $display("FAIL rr_grant%0d got %b want %0d", k, last_src, src);
            end
            tick(1);
            for (int w = 0; w < WORDS; w++) begin
                exp = exp_word_q.pop_front();
                n_cmp++;
                if (final_result[w*32 +: 32] !== exp) begin
                    n_err++;
                    $display("FAIL rr_frame%0d_word%0d got %h want %h", k, w, final_result[w*32 +: 32], exp);
                end
            end
            tick(1);
            n_cmp++;
            if (ack !== (src != 0 ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL rr_ack%0d got %b want src %0d", k, ack, src);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_admission();
        bit ok;
        int at;
        int frames;
        int s0;
        do_reset();
        req = 2'b01;
        frames = 0;
        for (int k = 0; k < 10; k++) begin
            wait_swe(k == 0 ? 10 : 250, ok, at);
            if (ok) frames++;
        end
        n_cmp++;
        if (frames != 10) begin
            n_err++;
            $display("FAIL adm_frames got %0d want 10", frames);
        end
        wait_idle(300, ok);
        n_cmp++;
        if (!ok || occupancy !== 11'd960) begin
            n_err++;
            $display("FAIL adm_full got ok=%0d occ=%0d want 1 960", ok, occupancy);
        end
        s0 = swe_count;
        tick(300);
        n_cmp++;
        if (swe_count != s0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL adm_blocked got starts=%0d busy=%b want 0 0", swe_count - s0, busy);
        end
        fifo_empty = 1'b0;
        host_rd_en = 1'b1;
        tick(32);
        host_rd_en = 1'b0;
        n_cmp++;
        if (occupancy !== 11'd928 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL adm_after_reads got occ=%0d busy=%b want 928 0", occupancy, busy);
        end
        tick(1);
        n_cmp++;
        if (ser_write_en !== 1'b1) begin
            n_err++;
            $display("FAIL adm_resume got %b want 1", ser_write_en);
        end
        host_rd_en = 1'b1;
        tick(1);
        host_rd_en = 1'b0;
        n_cmp++;
        if (occupancy !== 11'd1023) begin
            n_err++;
            $display("FAIL adm_start_with_read got %0d want 1023", occupancy);
        end
        req = 2'b00;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int at;
        logic [31:0] exp;
        do_reset();
        req = 2'b11;
        wait_swe(10, ok, at);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL mid_start got none want ser_write_en");
            req = 2'b00;
            return;
        end
        tick(49);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ser_write_en, ack, busy, occupancy, last_src} !== {1'b0, 2'b00, 1'b0, 11'd0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_async_reset got swe=%b ack=%b busy=%b occ=%0d last=%b want 0 00 0 0 1",
                     ser_write_en, ack, busy, occupancy, last_src);
        end
        tick(1);
        rst = 1'b0;
        push_frame(0);
        wait_swe(10, ok, at);
        n_cmp++;
        if (!ok || last_src !== 1'b0) begin
            n_err++;
            $display("FAIL mid_regrant got ok=%0d last=%b want 1 0", ok, last_src);
        end
        tick(1);
        void'(exp_src_q.pop_front());
        for (int w = 0; w < WORDS; w++) begin
            exp = exp_word_q.pop_front();
            n_cmp++;
            if (final_result[w*32 +: 32] !== exp) begin
                n_err++;
                $display("FAIL mid_word%0d got %h want %h", w, final_result[w*32 +: 32], exp);
            end
        end
        req = 2'b00;
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++) begin
            res0[w*32 +: 32] = 32'h5555_5555;
            res1[w*32 +: 32] = 32'hC0DE_0000 | 32'(w);
        end
        test_reset();
        test_single_frame();
        test_read_gating();
        test_round_robin();
        test_admission();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
